// File: rtl/pes_cla_subtractor_seq.sv
// pes_cla_subtractor_seq: multi-cycle a - b - bin, one 4-bit carry-lookahead nibble per clock
module pes_cla_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, diff_nxt;
  logic [CW-1:0] cnt;
  logic carry, c4;
  logic [3:0] an, bn, p, g, c;

  // Subtraction as a + ~b + carry, where the carry register holds the inverted borrow
  always_comb begin
    an = a_r[4*cnt +: 4];
    bn = b_r[4*cnt +: 4];
    p = an ^ ~bn;
    g = an & ~bn;
    c = {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & carry,
         g[1] | p[1] & g[0] | p[1] & p[0] & carry,
         g[0] | p[0] & carry,
         carry};
    c4 = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0] | (&p) & carry;
    diff_nxt = diff;
    diff_nxt[4*cnt +: 4] = p ^ c;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  always_comb
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (cnt == LAST ? DONE : RUN) :
                (out_ready ? IDLE : DONE);

  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      carry <= ~bin;
      cnt <= '0;
    end else if (state == RUN) begin
      diff <= diff_nxt;
      carry <= c4;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        bout <= ~c4;
        zero <= diff_nxt == '0;
        ovf <= (a_r[MSB] != b_r[MSB]) && (diff_nxt[MSB] != a_r[MSB]);
      end
    end
endmodule

// File: tb/tb_pes_cla_subtractor_seq.sv
// tb_pes_cla_subtractor_seq: scoreboard bench with directed and randomized subtractions
module tb_pes_cla_subtractor_seq;
  localparam int W = 16;
  localparam int NIB = W / 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic bo;
    logic z;
    logic ov;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, bin = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, bout, zero, ovf;
  logic [W-1:0] diff;
  bit rand_ready = 1'b0, fixed_ready = 1'b1, prev_ov = 1'b0, chk_idle = 1'b0;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  exp_t q[$];

  pes_cla_subtractor_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    int u, s;
    u = int'(x) - int'(y) - int'(bi);
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    e.d = W'(u);
    e.bo = u < 0;
    e.z = e.d == '0;
    e.ov = s > 32767 || s < -32768;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_ov = 1'b0;
      chk_idle = 1'b0;
    end else begin
      if (chk_idle)
        chk(in_ready == 1'b1, $sformatf("idle_return in_ready=%0b want 1", in_ready));
      chk_idle = 1'b0;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        acc_cyc = cyc;
      end
      if (out_valid && !prev_ov)
        chk(cyc - acc_cyc == NIB + 1, $sformatf("latency got=%0d want=%0d", cyc - acc_cyc - 1, NIB));
      if (out_valid) begin
        chk(!in_ready, $sformatf("busy_in_ready got=%0b want 0", in_ready));
        chk(q.size() > 0, "sb_nonempty got empty queue want pending result");
        if (q.size() > 0) begin
          chk({diff, bout, zero, ovf} == q[0],
              $sformatf("result got diff=%h bout=%0b zero=%0b ovf=%0b want diff=%h bout=%0b zero=%0b ovf=%0b",
                        diff, bout, zero, ovf, q[0].d, q[0].bo, q[0].z, q[0].ov));
          if (out_ready) begin
            void'(q.pop_front());
            chk_idle = 1'b1;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    bit ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    bin = bi;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk(ok, $sformatf("accept_timeout got in_ready=%0b want 1", in_ready));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic drain(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = q.size() == 0 && !out_valid && in_ready;
    end
    chk(ok, $sformatf("drain_timeout got pending=%0d want 0", q.size()));
  endtask

  task automatic chk_cleared(input string tag);
    chk({out_valid, diff, bout, zero, ovf} == '0 && in_ready,
        $sformatf("%s got out_valid=%0b diff=%h bout=%0b zero=%0b ovf=%0b in_ready=%0b want all 0, in_ready 1",
                  tag, out_valid, diff, bout, zero, ovf, in_ready));
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 chk_cleared("reset_state");
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready, $sformatf("release_in_ready got=%0b want 1", in_ready));
    send(16'h0005, 16'h0003, 1'b0);
    send(16'h0100, 16'h0001, 1'b0);
    send(16'h0003, 16'h0005, 1'b0);
    send(16'h8000, 16'h0001, 1'b0);
    send(16'h1234, 16'h1233, 1'b1);
    drain(100);
    fixed_ready = 1'b0;
    send(16'h4321, 16'h0123, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    chk(ok, $sformatf("bp_valid_timeout got out_valid=%0b want 1", out_valid));
    repeat (6) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
      chk(out_valid, $sformatf("bp_hold got out_valid=%0b want 1", out_valid));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    fixed_ready = 1'b1;
    drain(100);
    send(16'h1234, 16'h0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_cleared("async_reset");
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready, $sformatf("rerelease_in_ready got=%0b want 1", in_ready));
    send(16'hFFFF, 16'hFFFF, 1'b0);
    drain(100);
    rand_ready = 1'b1;
    repeat (1000) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain(500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
